board_update_arbiter: RTL and testbench

//  Owns the 8x8 board/highlight arrays and screen state feeding the VGA pixel generator.

---
 rtl/board_update_arbiter_if.sv | 44 ++++
 rtl/board_update_arbiter.sv | 178 +++++++++++++++++
 tb/tb_board_update_arbiter.sv | 367 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/board_update_arbiter_if.sv
// Shared screen-state type and the write-side bus of board_update_arbiter.
// master: game engine / UI side; slave: board_update_arbiter.
package board_update_pkg;
    typedef enum logic [1:0] {
        TITLE_SCREEN = 2'd0,
        CHESS_SCREEN = 2'd1,
        END_SCREEN   = 2'd2
    } screen_state_t;
endpackage

interface board_update_arbiter_if;
    import board_update_pkg::*;

    logic          a_valid;
    logic          a_ready;
    logic [2:0]    a_row;
    logic [2:0]    a_col;
    logic [3:0]    a_piece;

    logic          b_valid;
    logic          b_ready;
    logic [2:0]    b_row;
    logic [2:0]    b_col;
    logic          b_hl;
    logic          b_clr_all;

    logic          st_valid;
    logic          st_ready;
    screen_state_t st_req;

    modport master (
        output a_valid, a_row, a_col, a_piece,
        output b_valid, b_row, b_col, b_hl, b_clr_all,
        output st_valid, st_req,
        input  a_ready, b_ready, st_ready
    );

    modport slave (
        input  a_valid, a_row, a_col, a_piece,
        input  b_valid, b_row, b_col, b_hl, b_clr_all,
        input  st_valid, st_req,
        output a_ready, b_ready, st_ready
    );
endinterface

// File: rtl/board_update_arbiter.sv
// Board/highlight shadow arrays with round-robin A/B write arbitration,
// committed to the display copy once per frame at vblank start.
// Ports: vga_clk, reset_n (async, active-low), hcount/vcount (beam position),
//   bus (slave: piece writes A, highlight writes B, screen-state requests),
//   flip (only with BOARD_FLIP_EN: rotate board 180 deg at commit),
//   board_out/hl_out/state_out (display copy), frame_tick (commit pulse),
//   busy (uncommitted shadow writes or state request pending).
module board_update_arbiter
    import board_update_pkg::*;
#(
    parameter int         SCREEN_WIDTH  = 640,
    parameter int         SCREEN_HEIGHT = 480,
    parameter logic [3:0] EMPTY_CODE    = 4'd15
) (
    input  logic                  vga_clk,
    input  logic                  reset_n,
    input  logic [9:0]            hcount,
    input  logic [9:0]            vcount,
    board_update_arbiter_if.slave bus,
`ifdef BOARD_FLIP_EN
    input  logic                  flip,
`endif
    output logic [3:0]            board_out [8][8],
    output logic                  hl_out    [8][8],
    output screen_state_t         state_out,
    output logic                  frame_tick,
    output logic                  busy
);

    if (SCREEN_WIDTH < 1 || SCREEN_WIDTH > 799 ||
        SCREEN_HEIGHT < 1 || SCREEN_HEIGHT > 1023) begin : g_bad_geometry
        $error("board_update_arbiter: unsupported screen geometry");
    end

    localparam logic [9:0] TRIG_LINE = 10'(SCREEN_HEIGHT);

    typedef enum logic [1:0] {
        ACCEPT = 2'd0,
        CLEAR  = 2'd1,
        COMMIT = 2'd2
    } fsm_t;

    fsm_t          state_q, state_d;
    logic [2:0]    row_q;
    logic          commit_pend_q;
    logic          grant_b_last_q;
    logic          dirty_q;
    logic          st_pend_q;
    screen_state_t st_q;

    logic [3:0]    bd_sh [8][8];
    logic          hl_sh [8][8];

    logic trigger;
    logic a_rdy, b_rdy;
    logic a_fire, b_fire, st_fire;

    assign trigger = (hcount == 10'd0) && (vcount == TRIG_LINE);

    always_comb begin
        state_d = state_q;
        a_rdy   = 1'b0;
        b_rdy   = 1'b0;
        unique case (state_q)
            ACCEPT: begin
                if (trigger) begin
                    state_d = COMMIT;
                end else begin
                    // On contention the side not granted last wins.
                    if (bus.a_valid && bus.b_valid) begin
                        a_rdy = grant_b_last_q;
                        b_rdy = !grant_b_last_q;
                    end else begin
                        a_rdy = 1'b1;
                        b_rdy = 1'b1;
                    end
                    if (bus.b_valid && b_rdy && bus.b_clr_all)
                        state_d = CLEAR;
                end
            end
            CLEAR: begin
                if (row_q == 3'd7)
                    state_d = (commit_pend_q || trigger) ? COMMIT : ACCEPT;
            end
            COMMIT: state_d = ACCEPT;
            default: state_d = ACCEPT;
        endcase
    end

    assign bus.a_ready  = a_rdy;
    assign bus.b_ready  = b_rdy;
    assign bus.st_ready = !st_pend_q;

    assign a_fire  = bus.a_valid && a_rdy;
    assign b_fire  = bus.b_valid && b_rdy;
    assign st_fire = bus.st_valid && !st_pend_q;

    assign busy = dirty_q | st_pend_q;

    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= ACCEPT;
            row_q          <= 3'd0;
            commit_pend_q  <= 1'b0;
            grant_b_last_q <= 1'b1;
            dirty_q        <= 1'b0;
            st_pend_q      <= 1'b0;
            st_q           <= TITLE_SCREEN;
            state_out      <= TITLE_SCREEN;
            frame_tick     <= 1'b0;
            for (int r = 0; r < 8; r++) begin
                for (int c = 0; c < 8; c++) begin
                    bd_sh[r][c]     <= EMPTY_CODE;
                    hl_sh[r][c]     <= 1'b0;
                    board_out[r][c] <= EMPTY_CODE;
                    hl_out[r][c]    <= 1'b0;
                end
            end
        end else begin
            state_q    <= state_d;
            frame_tick <= (state_q == COMMIT);

            if (a_fire) begin
                bd_sh[bus.a_row][bus.a_col] <= bus.a_piece;
                grant_b_last_q              <= 1'b0;
                dirty_q                     <= 1'b1;
            end
            if (b_fire) begin
                if (!bus.b_clr_all)
                    hl_sh[bus.b_row][bus.b_col] <= bus.b_hl;
                grant_b_last_q <= 1'b1;
                dirty_q        <= 1'b1;
            end

            // Bulk clear walks one row per cycle; a vblank arriving
            // meanwhile is remembered and honoured after the last row.
            if (state_q == CLEAR) begin
                row_q <= row_q + 3'd1;
                for (int c = 0; c < 8; c++)
                    hl_sh[row_q][c] <= 1'b0;
                if (trigger)
                    commit_pend_q <= 1'b1;
                if (row_q == 3'd7)
                    commit_pend_q <= 1'b0;
            end else begin
                row_q <= 3'd0;
            end

            if (st_fire) begin
                st_pend_q <= 1'b1;
                st_q      <= bus.st_req;
            end

            if (state_q == COMMIT) begin
                for (int r = 0; r < 8; r++) begin
                    for (int c = 0; c < 8; c++) begin
`ifdef BOARD_FLIP_EN
                        if (flip) begin
                            board_out[r][c] <= bd_sh[7-r][7-c];
                            hl_out[r][c]    <= hl_sh[7-r][7-c];
                        end else
`endif
                        begin
                            board_out[r][c] <= bd_sh[r][c];
                            hl_out[r][c]    <= hl_sh[r][c];
                        end
                    end
                end
                if (st_pend_q) begin
                    state_out <= st_q;
                    st_pend_q <= 1'b0;
                end
                dirty_q <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_board_update_arbiter.sv
// Scoreboard bench for board_update_arbiter: stimulus pushes the expected
// display snapshot at each vblank trigger; a monitor checks it on frame_tick.
module tb_board_update_arbiter;
    import board_update_pkg::*;

    logic          vga_clk = 1'b0;
    logic          reset_n = 1'b0;
    logic [9:0]    hcount  = 10'd10;
    logic [9:0]    vcount  = 10'd100;
    logic [3:0]    board_out [8][8];
    logic          hl_out    [8][8];
    screen_state_t state_out;
    logic          frame_tick;
    logic          busy;
`ifdef BOARD_FLIP_EN
    logic          flip = 1'b0;
`endif

    board_update_arbiter_if bus();

    board_update_arbiter dut (
        .vga_clk   (vga_clk),
        .reset_n   (reset_n),
        .hcount    (hcount),
        .vcount    (vcount),
        .bus       (bus),
`ifdef BOARD_FLIP_EN
        .flip      (flip),
`endif
        .board_out (board_out),
        .hl_out    (hl_out),
        .state_out (state_out),
        .frame_tick(frame_tick),
        .busy      (busy)
    );

    always #5 vga_clk = ~vga_clk;

    typedef struct packed {
        logic [255:0]  bd;
        logic [63:0]   hl;
        screen_state_t st;
    } snap_t;

    snap_t exp_q[$];
    snap_t mon_e, mon_a;
    int    checks = 0;
    int    errors = 0;
    int    ticks  = 0;

    logic [3:0]    m_bd [8][8];
    logic          m_hl [8][8];
    screen_state_t m_disp_st, m_pend_val;
    logic          m_pend;

    task automatic chk(input string nm, input logic [319:0] act,
                       input logic [319:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, expv);
        end
    endtask

    function automatic snap_t pack_model();
        snap_t s;
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 8; c++) begin
                s.bd[(r*8+c)*4 +: 4] = m_bd[r][c];
                s.hl[r*8+c]          = m_hl[r][c];
            end
        s.st = m_pend ? m_pend_val : m_disp_st;
        return s;
    endfunction

    function automatic snap_t pack_dut();
        snap_t s;
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 8; c++) begin
                s.bd[(r*8+c)*4 +: 4] = board_out[r][c];
                s.hl[r*8+c]          = hl_out[r][c];
            end
        s.st = state_out;
        return s;
    endfunction

    task automatic model_reset();
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 8; c++) begin
                m_bd[r][c] = 4'd15;
                m_hl[r][c] = 1'b0;
            end
        m_disp_st  = TITLE_SCREEN;
        m_pend_val = TITLE_SCREEN;
        m_pend     = 1'b0;
        exp_q.delete();
    endtask

    // Monitor: every commit pulse must match the oldest expected snapshot.
    always @(negedge vga_clk) begin
        if (reset_n && frame_tick) begin
            ticks++;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL frame_tick: got unexpected commit, expected none");
            end else begin
                mon_e = exp_q.pop_front();
                mon_a = pack_dut();
                chk("commit board", mon_a.bd, mon_e.bd);
                chk("commit hl", mon_a.hl, mon_e.hl);
                chk("commit state", mon_a.st, mon_e.st);
            end
        end
    end

    // One clock: record accepted transfers, snapshot at the trigger.
    task automatic step();
        @(negedge vga_clk);
        if (bus.a_valid && bus.a_ready)
            m_bd[bus.a_row][bus.a_col] = bus.a_piece;
        if (bus.b_valid && bus.b_ready) begin
            if (bus.b_clr_all) begin
                for (int r = 0; r < 8; r++)
                    for (int c = 0; c < 8; c++)
                        m_hl[r][c] = 1'b0;
            end else begin
                m_hl[bus.b_row][bus.b_col] = bus.b_hl;
            end
        end
        if (bus.st_valid && bus.st_ready) begin
            m_pend     = 1'b1;
            m_pend_val = bus.st_req;
        end
        if (reset_n && hcount == 10'd0 && vcount == 10'd480) begin
            exp_q.push_back(pack_model());
            if (m_pend) m_disp_st = m_pend_val;
            m_pend = 1'b0;
        end
        @(posedge vga_clk);
        #1;
    endtask

    task automatic adv_pos();
        if (hcount == 10'd799) begin
            hcount = 10'd0;
            vcount = (vcount == 10'd524) ? 10'd0 : vcount + 10'd1;
        end else begin
            hcount = hcount + 10'd1;
        end
    endtask

    task automatic wait_commit(input int t0);
        int n = 0;
        while (ticks == t0 && n < 20) begin
            step();
            n++;
        end
        checks++;
        if (ticks == t0) begin
            errors++;
            $display("FAIL commit timeout: got no frame_tick, expected one within 20 cycles");
        end
    endtask

    task automatic frame();
        int t0 = ticks;
        hcount = 10'd0;
        vcount = 10'd480;
        step();
        hcount = 10'd10;
        vcount = 10'd100;
        wait_commit(t0);
    endtask

    task automatic idle_bus();
        bus.a_valid   = 1'b0;
        bus.a_row     = 3'd0;
        bus.a_col     = 3'd0;
        bus.a_piece   = 4'd0;
        bus.b_valid   = 1'b0;
        bus.b_row     = 3'd0;
        bus.b_col     = 3'd0;
        bus.b_hl      = 1'b0;
        bus.b_clr_all = 1'b0;
        bus.st_valid  = 1'b0;
        bus.st_req    = TITLE_SCREEN;
    endtask

    task automatic apply_reset();
        reset_n = 1'b0;
        idle_bus();
        model_reset();
        repeat (2) @(posedge vga_clk);
        #1;
        reset_n = 1'b1;
    endtask

    task automatic b_write(input int r, input int c, input logic v);
        bus.b_valid = 1'b1;
        bus.b_row   = 3'(r);
        bus.b_col   = 3'(c);
        bus.b_hl    = v;
        step();
        bus.b_valid = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int t0;
        apply_reset();

        // Reset state
        chk("reset board", pack_dut().bd, {64{4'hF}});
        chk("reset hl", pack_dut().hl, 64'd0);
        chk("reset state", state_out, TITLE_SCREEN);
        chk("reset a_ready", bus.a_ready, 1'b1);
        chk("reset b_ready", bus.b_ready, 1'b1);
        chk("reset st_ready", bus.st_ready, 1'b1);
        chk("reset busy", busy, 1'b0);

        // Piece write is invisible until the vblank commit
        bus.a_valid = 1'b1;
        bus.a_row   = 3'd2;
        bus.a_col   = 3'd3;
        bus.a_piece = 4'd5;
        #1;
        chk("a_ready single", bus.a_ready, 1'b1);
        step();
        bus.a_valid = 1'b0;
        chk("busy after write", busy, 1'b1);
        repeat (3) step();
        chk("pre-commit sq23", board_out[2][3], 4'd15);
        t0 = ticks;
        hcount = 10'd0;
        vcount = 10'd480;
        #1;
        chk("trigger a_ready", bus.a_ready, 1'b0);
        chk("trigger sq23", board_out[2][3], 4'd15);
        step();
        hcount = 10'd10;
        vcount = 10'd100;
        chk("commit-cycle sq23", board_out[2][3], 4'd15);
        wait_commit(t0);
        chk("post-commit sq23", board_out[2][3], 4'd5);
        chk("busy after commit", busy, 1'b0);

        // Round-robin contention from a fresh grant pointer: A,B,A,B
        apply_reset();
        for (int k = 0; k < 4; k++) begin
            bus.a_valid = 1'b1;
            bus.a_row   = 3'd4;
            bus.a_col   = 3'(k);
            bus.a_piece = 4'(k + 1);
            bus.b_valid = 1'b1;
            bus.b_row   = 3'd4;
            bus.b_col   = 3'(k);
            bus.b_hl    = 1'b1;
            #1;
            chk("rr a_ready", bus.a_ready, (k % 2 == 0));
            chk("rr b_ready", bus.b_ready, (k % 2 == 1));
            step();
        end
        idle_bus();
        frame();
        chk("rr sq40", board_out[4][0], 4'd1);
        chk("rr sq41", board_out[4][1], 4'd15);
        chk("rr sq42", board_out[4][2], 4'd3);
        chk("rr hl40", hl_out[4][0], 1'b0);
        chk("rr hl41", hl_out[4][1], 1'b1);
        chk("rr hl43", hl_out[4][3], 1'b1);

        // Clear-all issued just before vblank; commit waits for row 7
        b_write(1, 1, 1'b1);
        b_write(6, 6, 1'b1);
        hcount = 10'd797;
        vcount = 10'd479;
        bus.b_valid   = 1'b1;
        bus.b_clr_all = 1'b1;
        #1;
        chk("clr b_ready", bus.b_ready, 1'b1);
        step();
        bus.b_valid   = 1'b0;
        bus.b_clr_all = 1'b0;
        adv_pos();
        bus.a_valid = 1'b1;
        bus.a_row   = 3'd7;
        bus.a_col   = 3'd7;
        bus.a_piece = 4'd9;
        #1;
        chk("clear a_ready", bus.a_ready, 1'b0);
        t0 = ticks;
        for (int i = 0; i < 14; i++) begin
            step();
            adv_pos();
        end
        bus.a_valid = 1'b0;
        hcount = 10'd10;
        vcount = 10'd100;
        chk("clear commits", ticks - t0, 1);
        chk("clear hl11", hl_out[1][1], 1'b0);
        chk("clear sq77 late", board_out[7][7], 4'd15);
        chk("busy late write", busy, 1'b1);

        // Single-entry state request register
        bus.st_valid = 1'b1;
        bus.st_req   = CHESS_SCREEN;
        #1;
        chk("st_ready first", bus.st_ready, 1'b1);
        step();
        bus.st_req = END_SCREEN;
        #1;
        chk("st_ready pending", bus.st_ready, 1'b0);
        repeat (3) step();
        chk("st_ready stall", bus.st_ready, 1'b0);
        chk("state before commit", state_out, TITLE_SCREEN);
        frame();
        bus.st_valid = 1'b0;
        chk("state commit1", state_out, CHESS_SCREEN);
        chk("busy second st", busy, 1'b1);
        frame();
        chk("state commit2", state_out, END_SCREEN);
        chk("sq77 committed", board_out[7][7], 4'd9);

        // Reset in the middle of a clear that has already seen vblank
        b_write(0, 0, 1'b1);
        hcount = 10'd797;
        vcount = 10'd479;
        bus.b_valid   = 1'b1;
        bus.b_clr_all = 1'b1;
        step();
        bus.b_valid   = 1'b0;
        bus.b_clr_all = 1'b0;
        for (int i = 0; i < 4; i++) begin
            adv_pos();
            step();
        end
        #2;
        reset_n = 1'b0;
        #1;
        chk("midclr board", pack_dut().bd, {64{4'hF}});
        chk("midclr hl", pack_dut().hl, 64'd0);
        chk("midclr state", state_out, TITLE_SCREEN);
        chk("midclr tick", frame_tick, 1'b0);
        chk("midclr busy", busy, 1'b0);
        model_reset();
        hcount = 10'd10;
        vcount = 10'd100;
        @(posedge vga_clk);
        #1;
        reset_n = 1'b1;
        t0 = ticks;
        repeat (15) step();
        chk("no stale commit", ticks - t0, 0);
        chk("post-reset a_ready", bus.a_ready, 1'b1);
        chk("leftover expects", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
